// File: rtl/key_sequencer_pkg.sv
// Shared types, widths and DES key-schedule tables for the key sequencer.
package key_seq_pkg;

  localparam int unsigned KEY_W  = 32'd64;
  localparam int unsigned CD_W   = 32'd56;
  localparam int unsigned RK_W   = 32'd48;
  localparam int unsigned HALF_W = 32'd28;
  localparam int unsigned ROUNDS = 32'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam logic [1:0] SHIFT_TAB [ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Entries are FIPS bit numbers (1 = MSB of the source word).
  localparam logic [6:0] PC1_TAB [CD_W] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [5:0] PC2_TAB [RK_W] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] h, input logic [1:0] s);
    logic [HALF_W-1:0] r;
    case (s)
      2'd1:    r = {h[HALF_W-2:0], h[HALF_W-1]};
      2'd2:    r = {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]};
      default: r = h;
    endcase
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] h, input logic [1:0] s);
    logic [HALF_W-1:0] r;
    case (s)
      2'd1:    r = {h[0], h[HALF_W-1:1]};
      2'd2:    r = {h[1:0], h[HALF_W-1:2]};
      default: r = h;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_sequencer_sched.sv
// Combinational DES key-schedule pieces: PC-1 front end and one
// left-rotate + PC-2 round stage.
module perm_PC1
  import key_seq_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  output logic [CD_W-1:0]  cd
);

  for (genvar i = 0; i < CD_W; i++) begin : g_bit
    assign cd[CD_W-1-i] = key[KEY_W-PC1_TAB[i]];
  end

endmodule

module key_schedule
  import key_seq_pkg::*;
(
  input  logic [CD_W-1:0] cd,
  input  logic [3:0]      round,
  output logic [CD_W-1:0] cd_next,
  output logic [RK_W-1:0] rk
);

  logic [1:0] shift_s;

  assign shift_s = SHIFT_TAB[round];
  assign cd_next = {rotl(cd[CD_W-1:HALF_W], shift_s), rotl(cd[HALF_W-1:0], shift_s)};

  for (genvar i = 0; i < RK_W; i++) begin : g_bit
    assign rk[RK_W-1-i] = cd_next[CD_W-PC2_TAB[i]];
  end

endmodule

// File: rtl/key_sequencer.sv
// DES round-key sequencer with valid/ready output. Define KEY_STORE_EN to add
// a 16x48 key store (LOAD phase, replay without reloading the key).
module key_sequencer
  import key_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key,
  input  logic             dec,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             replay,
  output logic [RK_W-1:0]  rk,
  output logic [3:0]       rk_idx,
  output logic             rk_last,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             busy
);

  state_e          state_r, state_n;
  logic [CD_W-1:0] cd_r, pc1_s, ks_in_s, ks_next_s, cd_step_s;
  logic [RK_W-1:0] ks_rk_s, emit_rk_s, rk_r;
  logic [4:0]      cnt_r;
  logic [3:0]      gen_idx_s, ks_round_s, rk_idx_r;
  logic            dec_r, accept_s, replay_go_s, replay_ok_s, advance_s, done_s;
  logic            rk_last_r, rk_valid_r, busy_r, key_ready_r;

  perm_PC1 u_pc1 (.key(key), .cd(pc1_s));

  key_schedule u_ks (
    .cd     (ks_in_s),
    .round  (ks_round_s),
    .cd_next(ks_next_s),
    .rk     (ks_rk_s)
  );

  // cnt_r counts keys produced; decrypt walks the round index downwards.
  assign gen_idx_s = dec_r ? (4'd15 - cnt_r[3:0]) : cnt_r[3:0];
  assign advance_s = !rk_valid_r || rk_ready;
  assign done_s    = rk_valid_r && rk_ready && rk_last_r;

`ifdef KEY_STORE_EN
  localparam state_e ACCEPT_ST = LOAD;

  logic [RK_W-1:0] store_r [ROUNDS];
  logic            stored_r;

  assign ks_in_s     = cd_r;
  assign ks_round_s  = cnt_r[3:0];
  assign cd_step_s   = ks_next_s;
  assign emit_rk_s   = store_r[gen_idx_s];
  assign replay_ok_s = replay && stored_r;

  // Key store written in forward order during LOAD
  always_ff @(posedge clk) begin
    if (state_r == LOAD) begin
      store_r[cnt_r[3:0]] <= ks_rk_s;
    end
  end

  // Store-full flag; only a completed LOAD makes replay legal
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stored_r <= 1'b0;
    end else if (state_r == LOAD && cnt_r == 5'd15) begin
      stored_r <= 1'b1;
    end
  end
`else
  localparam state_e ACCEPT_ST = EMIT;

  logic [CD_W-1:0] rotr_s;
  logic [1:0]      rshift_s;
  logic            unused_replay_s;

  // C16D16 == C0D0, so decrypt starts from the loaded state and undoes each
  // round's shift; feeding the un-rotated state back through the stage
  // re-applies that shift and yields PC-2 of the current state.
  assign rshift_s        = SHIFT_TAB[gen_idx_s];
  assign rotr_s          = {rotr(cd_r[CD_W-1:HALF_W], rshift_s), rotr(cd_r[HALF_W-1:0], rshift_s)};
  assign ks_in_s         = dec_r ? rotr_s : cd_r;
  assign ks_round_s      = gen_idx_s;
  assign cd_step_s       = dec_r ? rotr_s : ks_next_s;
  assign emit_rk_s       = ks_rk_s;
  assign replay_ok_s     = 1'b0;
  assign unused_replay_s = replay;
`endif

  // Next-state decode; key acceptance wins over replay
  always_comb begin
    state_n     = state_r;
    accept_s    = 1'b0;
    replay_go_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (key_valid) begin
          accept_s = 1'b1;
          state_n  = ACCEPT_ST;
        end else if (replay_ok_s) begin
          replay_go_s = 1'b1;
          state_n     = EMIT;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (cnt_r == 5'd15) state_n = EMIT;
        else                state_n = LOAD;
      end
      EMIT: begin
        if (done_s) state_n = IDLE;
        else        state_n = EMIT;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      key_ready_r <= 1'b1;
    end else begin
      state_r     <= state_n;
      busy_r      <= (state_n != IDLE);
      key_ready_r <= (state_n == IDLE);
    end
  end

  // Key state, counter and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cd_r       <= '0;
      cnt_r      <= 5'd0;
      dec_r      <= 1'b0;
      rk_r       <= '0;
      rk_idx_r   <= 4'd0;
      rk_last_r  <= 1'b0;
      rk_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cd_r  <= pc1_s;
            dec_r <= dec;
            cnt_r <= 5'd0;
          end else if (replay_go_s) begin
            dec_r <= dec;
            cnt_r <= 5'd0;
          end
        end
        LOAD: begin
          cd_r  <= ks_next_s;
          cnt_r <= (cnt_r == 5'd15) ? 5'd0 : cnt_r + 5'd1;
        end
        EMIT: begin
          if (advance_s) begin
            if (done_s) begin
              rk_valid_r <= 1'b0;
            end else begin
              rk_r       <= emit_rk_s;
              rk_idx_r   <= gen_idx_s;
              rk_last_r  <= (cnt_r == 5'd15);
              rk_valid_r <= 1'b1;
              cd_r       <= cd_step_s;
              cnt_r      <= cnt_r + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rk        = rk_r;
  assign rk_idx    = rk_idx_r;
  assign rk_last   = rk_last_r;
  assign rk_valid  = rk_valid_r;
  assign busy      = busy_r;
  assign key_ready = key_ready_r;

endmodule
